platform_rom_arbiter: RTL and testbench

Sequences and shares the platform sprite ROM between two requesters: the VGA pixel fetch path, which has priority, and the game controller's collision/probe port, which uses a req/ack handshake. The block owns the animation frame index. The index advances on vertical-sync ticks instead of a free-running counter, so frame changes never tear mid-screen. It sits between the VGA renderer, the game controller and the ROM, and drives all ROM address, size and frame inputs.

---
 rtl/platform_rom_arbiter.sv | 174 +++++++++++++++++
 tb/tb_platform_rom_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/platform_rom_arbiter.sv
// Shares the platform sprite ROM between the VGA pixel fetch (priority) and the game controller
// probe port, and owns the vsync-paced animation frame index.
module platform_rom_arbiter #(
    parameter int unsigned ADDR_W      = 19,
    parameter int unsigned FRAME_TICKS = 8,
    parameter int unsigned STARVE_MAX  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              vsync_pulse_i,
    input  logic              anim_en_i,
    input  logic              vga_req_i,
    input  logic [ADDR_W-1:0] vga_addr_i,
    input  logic [7:0]        vga_size_i,
    output logic              vga_valid_o,
    output logic [3:0]        vga_data_o,
    output logic              vga_drop_o,
    input  logic              gc_req_i,
    input  logic [ADDR_W-1:0] gc_addr_i,
    input  logic [7:0]        gc_size_i,
    output logic              gc_ack_o,
    output logic [3:0]        gc_data_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic [7:0]        rom_size_o,
    output logic [1:0]        rom_frame_o,
    input  logic [3:0]        rom_data_i,
    output logic              size_err_o
);
    localparam int unsigned TickW   = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {OwnNone, OwnVga, OwnGc, OwnGcDrop} owner_e;

    logic [1:0]         frame_q, frame_d;
    logic [TickW-1:0]   tick_q, tick_d;
    logic [StarveW-1:0] starve_q, starve_d;
    logic               gc_inflight_q, gc_inflight_d;
    logic               size_err_q, size_err_d;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic [7:0]         rom_size_q, rom_size_d;
    logic [1:0]         rom_frame_q, rom_frame_d;
    owner_e             own0_q, own0_d, own1_q;
    logic               vga_valid_q, vga_valid_d;
    logic               vga_drop_q, vga_drop_d;
    logic               gc_ack_q, gc_ack_d;
    logic [3:0]         vga_data_q, vga_data_d;
    logic [3:0]         gc_data_q, gc_data_d;

    logic       gc_elig, grant_vga, grant_gc, drop;
    logic [7:0] sel_size;
    logic       size_legal;

    always_comb begin
        frame_d       = frame_q;
        tick_d        = tick_q;
        starve_d      = starve_q;
        gc_inflight_d = gc_inflight_q;
        size_err_d    = size_err_q;
        rom_addr_d    = rom_addr_q;
        rom_size_d    = rom_size_q;
        rom_frame_d   = rom_frame_q;
        own0_d        = OwnNone;
        vga_data_d    = vga_data_q;
        gc_data_d     = gc_data_q;
        grant_vga     = 1'b0;
        grant_gc      = 1'b0;
        drop          = 1'b0;

        // An acked probe is not eligible in its ack cycle, so a held gc_req cannot double-grant.
        gc_elig = gc_req_i & ~gc_inflight_q & ~gc_ack_q;

        if (vga_req_i && gc_elig) begin
            if (starve_q == StarveW'(STARVE_MAX)) begin
                grant_gc = 1'b1;
                drop     = 1'b1;
            end else begin
                grant_vga = 1'b1;
                starve_d  = starve_q + 1'b1;
            end
        end else if (vga_req_i) begin
            grant_vga = 1'b1;
        end else if (gc_elig) begin
            grant_gc = 1'b1;
        end

        sel_size   = grant_gc ? gc_size_i : vga_size_i;
        size_legal = (sel_size == 8'd16) || (sel_size == 8'd32) ||
                     (sel_size == 8'd64) || (sel_size == 8'd128);

        if (grant_vga || grant_gc) begin
            rom_addr_d  = grant_gc ? gc_addr_i : vga_addr_i;
            rom_size_d  = size_legal ? sel_size : 8'd64;
            rom_frame_d = frame_q;
            if (!size_legal) begin
                size_err_d = 1'b1;
            end
            if (grant_gc) begin
                own0_d        = drop ? OwnGcDrop : OwnGc;
                starve_d      = '0;
                gc_inflight_d = 1'b1;
            end else begin
                own0_d = OwnVga;
            end
        end

        // Response slot: the owner tag has travelled two stages alongside the ROM access.
        vga_valid_d = (own1_q == OwnVga);
        vga_drop_d  = (own1_q == OwnGcDrop);
        gc_ack_d    = (own1_q == OwnGc) || (own1_q == OwnGcDrop);
        if (vga_valid_d) begin
            vga_data_d = rom_data_i;
        end
        if (gc_ack_d) begin
            gc_data_d     = rom_data_i;
            gc_inflight_d = 1'b0;
        end

        if (vsync_pulse_i && anim_en_i) begin
            if (tick_q == TickW'(FRAME_TICKS - 1)) begin
                tick_d  = '0;
                frame_d = frame_q + 2'd1;
            end else begin
                tick_d = tick_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_q       <= '0;
            tick_q        <= '0;
            starve_q      <= '0;
            gc_inflight_q <= 1'b0;
            size_err_q    <= 1'b0;
            rom_addr_q    <= '0;
            rom_size_q    <= '0;
            rom_frame_q   <= '0;
            own0_q        <= OwnNone;
            own1_q        <= OwnNone;
            vga_valid_q   <= 1'b0;
            vga_drop_q    <= 1'b0;
            gc_ack_q      <= 1'b0;
            vga_data_q    <= '0;
            gc_data_q     <= '0;
        end else begin
            frame_q       <= frame_d;
            tick_q        <= tick_d;
            starve_q      <= starve_d;
            gc_inflight_q <= gc_inflight_d;
            size_err_q    <= size_err_d;
            rom_addr_q    <= rom_addr_d;
            rom_size_q    <= rom_size_d;
            rom_frame_q   <= rom_frame_d;
            own0_q        <= own0_d;
            own1_q        <= own0_q;
            vga_valid_q   <= vga_valid_d;
            vga_drop_q    <= vga_drop_d;
            gc_ack_q      <= gc_ack_d;
            vga_data_q    <= vga_data_d;
            gc_data_q     <= gc_data_d;
        end
    end

    assign vga_valid_o = vga_valid_q;
    assign vga_data_o  = vga_data_q;
    assign vga_drop_o  = vga_drop_q;
    assign gc_ack_o    = gc_ack_q;
    assign gc_data_o   = gc_data_q;
    assign rom_addr_o  = rom_addr_q;
    assign rom_size_o  = rom_size_q;
    assign rom_frame_o = rom_frame_q;
    assign size_err_o  = size_err_q;

endmodule

// File: tb/tb_platform_rom_arbiter.sv
// Directed and randomized bench for platform_rom_arbiter, checked against a transaction-level
// model built from a response queue and plain integer counters.
module tb_platform_rom_arbiter;
    localparam int unsigned ADDR_W      = 19;
    localparam int unsigned FRAME_TICKS = 8;
    localparam int unsigned STARVE_MAX  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, vsync, anim_en, vga_req, gc_req;
    logic [ADDR_W-1:0] vga_addr, gc_addr;
    logic [7:0]        vga_size, gc_size;
    logic              vga_valid, vga_drop, gc_ack, size_err;
    logic [3:0]        vga_data, gc_data, rom_data;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_size;
    logic [1:0]        rom_frame;

    platform_rom_arbiter #(
        .ADDR_W      (ADDR_W),
        .FRAME_TICKS (FRAME_TICKS),
        .STARVE_MAX  (STARVE_MAX)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .vsync_pulse_i (vsync),
        .anim_en_i     (anim_en),
        .vga_req_i     (vga_req),
        .vga_addr_i    (vga_addr),
        .vga_size_i    (vga_size),
        .vga_valid_o   (vga_valid),
        .vga_data_o    (vga_data),
        .vga_drop_o    (vga_drop),
        .gc_req_i      (gc_req),
        .gc_addr_i     (gc_addr),
        .gc_size_i     (gc_size),
        .gc_ack_o      (gc_ack),
        .gc_data_o     (gc_data),
        .rom_addr_o    (rom_addr),
        .rom_size_o    (rom_size),
        .rom_frame_o   (rom_frame),
        .rom_data_i    (rom_data),
        .size_err_o    (size_err)
    );

    // ROM contents depend on address, size and frame so each select is observable in the data.
    function automatic logic [3:0] rom_fn(logic [ADDR_W-1:0] a, logic [7:0] s, int f);
        logic [1:0] fr;
        fr = f[1:0];
        return a[3:0] ^ s[7:4] ^ {fr, 2'b00};
    endfunction

    always @(posedge clk) rom_data <= rom_fn(rom_addr, rom_size, int'(rom_frame));

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        int         due;
        int         kind;   // 0 vga, 1 gc, 2 gc with vga dropped
        logic [3:0] data;
    } resp_t;

    resp_t             q[$];
    int                edge_n = 0;
    int                m_frame, m_tick, m_starve;
    bit                m_busy, m_err;
    bit                e_vga_valid, e_vga_drop, e_gc_ack;
    logic [3:0]        e_vga_data, e_gc_data;
    logic [ADDR_W-1:0] e_rom_addr;
    logic [7:0]        e_rom_size;
    int                e_rom_frame;

    function automatic bit legal(logic [7:0] s);
        return (s == 8'd16) || (s == 8'd32) || (s == 8'd64) || (s == 8'd128);
    endfunction

    task automatic model_reset();
        q.delete();
        m_frame = 0; m_tick = 0; m_starve = 0; m_busy = 0; m_err = 0;
        e_vga_valid = 0; e_vga_drop = 0; e_gc_ack = 0;
        e_vga_data = '0; e_gc_data = '0; e_rom_addr = '0; e_rom_size = '0; e_rom_frame = 0;
    endtask

    // Predict one clock edge from the current inputs, apply it, then compare every output.
    task automatic step();
        bit         gc_el, g_vga, g_gc, drp;
        logic [7:0] sz;
        resp_t      r;
        edge_n++;
        gc_el = gc_req && !m_busy && !e_gc_ack;
        g_vga = 0; g_gc = 0; drp = 0;
        if (vga_req && gc_el) begin
            if (m_starve >= STARVE_MAX) begin g_gc = 1; drp = 1; end
            else begin g_vga = 1; m_starve++; end
        end else if (vga_req) g_vga = 1;
        else if (gc_el) g_gc = 1;
        e_vga_valid = 0; e_vga_drop = 0; e_gc_ack = 0;
        if (rst) begin
            model_reset();
        end else begin
            if (q.size() > 0 && q[0].due == edge_n) begin
                r = q.pop_front();
                if (r.kind == 0) begin
                    e_vga_valid = 1; e_vga_data = r.data;
                end else begin
                    e_gc_ack = 1; e_gc_data = r.data; m_busy = 0;
                    e_vga_drop = (r.kind == 2);
                end
            end
            if (g_vga || g_gc) begin
                sz = g_gc ? gc_size : vga_size;
                if (!legal(sz)) begin sz = 8'd64; m_err = 1; end
                e_rom_addr  = g_gc ? gc_addr : vga_addr;
                e_rom_size  = sz;
                e_rom_frame = m_frame;
                q.push_back('{edge_n + 2, g_gc ? (drp ? 2 : 1) : 0,
                              rom_fn(e_rom_addr, sz, m_frame)});
                if (g_gc) begin m_busy = 1; m_starve = 0; end
            end
            if (vsync && anim_en) begin
                if (m_tick == FRAME_TICKS - 1) begin
                    m_tick = 0; m_frame = (m_frame + 1) % 4;
                end else m_tick++;
            end
        end
        @(posedge clk);
        #1;
        check_eq("vga_valid", 32'(vga_valid), 32'(e_vga_valid));
        check_eq("vga_drop", 32'(vga_drop), 32'(e_vga_drop));
        check_eq("vga_data", 32'(vga_data), 32'(e_vga_data));
        check_eq("gc_ack", 32'(gc_ack), 32'(e_gc_ack));
        check_eq("gc_data", 32'(gc_data), 32'(e_gc_data));
        check_eq("rom_addr", 32'(rom_addr), 32'(e_rom_addr));
        check_eq("rom_size", 32'(rom_size), 32'(e_rom_size));
        check_eq("rom_frame", 32'(rom_frame), 32'(e_rom_frame));
        check_eq("size_err", 32'(size_err), 32'(m_err));
    endtask

    initial begin
        int drops, drop_at, acks;
        model_reset();
        rst = 1; vsync = 0; anim_en = 1; vga_req = 0; gc_req = 0;
        vga_addr = '0; gc_addr = '0; vga_size = 8'd64; gc_size = 8'd64;
        step(); step();
        rst = 0;
        repeat (3) step();

        // Continuous VGA stream, incrementing address.
        vga_req = 1;
        for (int i = 0; i < 20; i++) begin
            vga_addr = ADDR_W'(i);
            step();
        end
        vga_req = 0;
        step(); step(); step();

        // Lone probe: ack two edges after grant, held req through ack must not regrant.
        gc_req = 1; gc_addr = 19'h155; gc_size = 8'd32;
        step();
        check_eq("gc_grant_size", 32'(rom_size), 32'd32);
        step();
        check_eq("gc_ack_early", 32'(gc_ack), 32'd0);
        step();
        check_eq("gc_ack_lat", 32'(gc_ack), 32'd1);
        check_eq("gc_data_dir", 32'(gc_data), 32'h7);
        step();
        gc_req = 0;
        acks = 0;
        repeat (4) begin step(); acks += int'(gc_ack); end
        check_eq("gc_no_regrant", 32'(acks), 32'd0);

        // Starvation: gc forced through on the 17th contention cycle.
        vga_req = 1; vga_size = 8'd64; gc_req = 1; gc_addr = 19'h0a3; gc_size = 8'd128;
        drops = 0; drop_at = 0;
        for (int i = 1; i <= 30; i++) begin
            vga_addr = ADDR_W'(i + 100);
            step();
            if (vga_drop) begin drops++; drop_at = i; end
            if (e_gc_ack) gc_req = 0;
        end
        check_eq("drop_count", 32'(drops), 32'd1);
        check_eq("drop_slot", 32'(drop_at), 32'(STARVE_MAX + 3));

        // Animation: frame advances every FRAME_TICKS pulses, frozen when anim_en is low.
        for (int p = 1; p <= 33; p++) begin
            vsync = 1; step(); vsync = 0; step();
            if (p == 8)  check_eq("frame_p8", 32'(rom_frame), 32'd1);
            if (p == 24) check_eq("frame_p24", 32'(rom_frame), 32'd3);
            if (p == 33) check_eq("frame_p33", 32'(rom_frame), 32'd0);
        end
        anim_en = 0;
        repeat (10) begin vsync = 1; step(); vsync = 0; step(); end
        check_eq("frame_frozen", 32'(rom_frame), 32'd0);
        anim_en = 1;
        repeat (7) begin vsync = 1; step(); vsync = 0; step(); end
        check_eq("frame_resume", 32'(rom_frame), 32'd1);

        // Illegal size: substituted and sticky until reset.
        vga_size = 8'd100; step();
        check_eq("bad_size_sub", 32'(rom_size), 32'd64);
        vga_size = 8'd16;
        repeat (4) step();
        check_eq("size_err_sticky", 32'(size_err), 32'd1);
        vga_req = 0; rst = 1; step(); rst = 0;
        check_eq("size_err_clr", 32'(size_err), 32'd0);

        // Reset mid-probe: the aborted request is never acked.
        gc_req = 1; gc_addr = 19'h2f; step();
        gc_req = 0; rst = 1; step(); rst = 0;
        acks = 0;
        repeat (5) begin step(); acks += int'(gc_ack); end
        check_eq("no_ack_after_rst", 32'(acks), 32'd0);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 299) == 0);
            vsync   = ($urandom_range(0, 3) == 0);
            anim_en = ($urandom_range(0, 7) != 0);
            vga_req = ($urandom_range(0, 3) != 0);
            vga_addr = ADDR_W'($urandom);
            vga_size = ($urandom_range(0, 9) == 0) ? 8'($urandom)
                                                   : 8'(16 << $urandom_range(0, 3));
            if (e_gc_ack) begin
                gc_req = 0;
            end else if (!gc_req && $urandom_range(0, 3) == 0) begin
                gc_req  = 1;
                gc_addr = ADDR_W'($urandom);
                gc_size = ($urandom_range(0, 9) == 0) ? 8'($urandom)
                                                      : 8'(16 << $urandom_range(0, 3));
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
